// File: rtl/diff_patch_pkg.sv
// Shared types and constants for the diff patch applier: FSM state encoding,
// the end-of-patch index value and default word/index widths.
package diff_patch_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int IDX_W_DEF = 6;
    localparam int IDX_END   = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/diff_patch_applier_if.sv
// Handshake bundle for the patch applier: base word in, index stream in, result out.
// The slave modport is the applier's view; master is the producer/consumer side.
interface diff_patch_if
    import diff_patch_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) ();

    logic             base_valid;
    logic [WIDTH-1:0] base_in;
    logic             base_ready;
    logic             idx_valid;
    logic [IDX_W-1:0] idx_in;
    logic             idx_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [IDX_W-1:0] out_count;
    logic             bad_idx;
    logic             order_err;

    modport slave (
        input  base_valid, base_in, idx_valid, idx_in, out_ready,
        output base_ready, idx_ready, out_valid, out_data, out_count, bad_idx, order_err
    );

    modport master (
        output base_valid, base_in, idx_valid, idx_in, out_ready,
        input  base_ready, idx_ready, out_valid, out_data, out_count, bad_idx, order_err
    );

endinterface

// File: rtl/diff_idx_decoder.sv
// Turns a 1-based bit-position index into a one-hot toggle mask; index 0 and
// positions beyond WIDTH decode to an empty mask with in_range low.
module diff_idx_decoder
    import diff_patch_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic [IDX_W-1:0] idx_in,
    output logic [WIDTH-1:0] mask,
    output logic             in_range
);

    always_comb begin
        mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask[i] = (idx_in == IDX_W'(i + 1));
        end
    end

    assign in_range = |mask;

endmodule

// File: rtl/diff_patch_applier.sv
// Rebuilds a word from a base plus a stream of 1-based bit toggles (0 ends the patch).
// Optional macro DIFF_PATCH_ORDER_CHECK_EN flags non-ascending in-range indices.
module diff_patch_applier
    import diff_patch_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input logic      clk,
    input logic      rst,
    diff_patch_if.slave bus
);

    function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic             bad_q, bad_d;
    logic [WIDTH-1:0] tog_mask;
    logic             in_range;
    logic             is_end;

    diff_idx_decoder #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_dec (
        .idx_in   (bus.idx_in),
        .mask     (tog_mask),
        .in_range (in_range)
    );

    assign is_end = (bus.idx_in == IDX_W'(IDX_END));

`ifdef DIFF_PATCH_ORDER_CHECK_EN
    logic [IDX_W-1:0] last_idx_q, last_idx_d;
    logic             order_q, order_d;
`endif

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        count_d = count_q;
        bad_d   = bad_q;
`ifdef DIFF_PATCH_ORDER_CHECK_EN
        last_idx_d = last_idx_q;
        order_d    = order_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.base_valid) begin
                    work_d  = bus.base_in;
                    count_d = '0;
                    bad_d   = 1'b0;
`ifdef DIFF_PATCH_ORDER_CHECK_EN
                    last_idx_d = '0;
                    order_d    = 1'b0;
`endif
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (bus.idx_valid) begin
                    if (is_end) begin
                        state_d = ST_DONE;
                    end else if (in_range) begin
                        work_d  = work_q ^ tog_mask;
                        count_d = sat_inc(count_q);
`ifdef DIFF_PATCH_ORDER_CHECK_EN
                        // Toggle is still applied; the flag only reports the ordering break.
                        if (bus.idx_in <= last_idx_q) order_d = 1'b1;
                        last_idx_d = bus.idx_in;
`endif
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            count_q <= '0;
            bad_q   <= 1'b0;
`ifdef DIFF_PATCH_ORDER_CHECK_EN
            last_idx_q <= '0;
            order_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
            bad_q   <= bad_d;
`ifdef DIFF_PATCH_ORDER_CHECK_EN
            last_idx_q <= last_idx_d;
            order_q    <= order_d;
`endif
        end
    end

    assign bus.base_ready = (state_q == ST_IDLE);
    assign bus.idx_ready  = (state_q == ST_COLLECT);
    assign bus.out_valid  = (state_q == ST_DONE);
    assign bus.out_data   = work_q;
    assign bus.out_count  = count_q;
    assign bus.bad_idx    = bad_q;
`ifdef DIFF_PATCH_ORDER_CHECK_EN
    assign bus.order_err  = order_q;
`else
    assign bus.order_err  = 1'b0;
`endif

endmodule

// File: tb/tb_diff_patch_applier.sv
// Directed bench for diff_patch_applier: hand-computed patches, stalls and mid-patch reset.
module tb_diff_patch_applier;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

`ifdef DIFF_PATCH_ORDER_CHECK_EN
    localparam logic ORD = 1'b1;
`else
    localparam logic ORD = 1'b0;
`endif

    always #5 clk = ~clk;

    diff_patch_if #(.WIDTH(32), .IDX_W(6)) bus ();

    diff_patch_applier #(.WIDTH(32), .IDX_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_base(input logic [31:0] v);
        chk("base_ready_before_accept", {31'd0, bus.base_ready}, 32'd1);
        bus.base_valid = 1'b1;
        bus.base_in    = v;
        step();
        bus.base_valid = 1'b0;
        chk("idx_ready_after_base", {31'd0, bus.idx_ready}, 32'd1);
    endtask

    task automatic send_idx(input logic [5:0] v);
        bus.idx_valid = 1'b1;
        bus.idx_in    = v;
        step();
        bus.idx_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [31:0] data, input logic [5:0] cnt,
                             input logic bad, input logic ord);
        chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, "_out_data"},  bus.out_data, data);
        chk({tag, "_out_count"}, {26'd0, bus.out_count}, {26'd0, cnt});
        chk({tag, "_bad_idx"},   {31'd0, bus.bad_idx}, {31'd0, bad});
        chk({tag, "_order_err"}, {31'd0, bus.order_err}, {31'd0, ord});
    endtask

    task automatic take_out(input string tag);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({tag, "_out_valid_cleared"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_base_ready_back"},   {31'd0, bus.base_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.base_valid = 1'b0;
        bus.base_in    = '0;
        bus.idx_valid  = 1'b0;
        bus.idx_in     = '0;
        bus.out_ready  = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        chk("rst_base_ready", {31'd0, bus.base_ready}, 32'd1);
        chk("rst_idx_ready",  {31'd0, bus.idx_ready},  32'd0);
        chk("rst_out_valid",  {31'd0, bus.out_valid},  32'd0);
        chk("rst_out_count",  {26'd0, bus.out_count},  32'd0);
        chk("rst_bad_idx",    {31'd0, bus.bad_idx},    32'd0);
        chk("rst_order_err",  {31'd0, bus.order_err},  32'd0);
        chk("rst_out_data",   bus.out_data,            32'd0);

        // Two toggles at the extreme bit positions.
        send_base(32'h0000_0000);
        send_idx(6'd1);
        send_idx(6'd32);
        send_idx(6'd0);
        check_out("t1", 32'h8000_0001, 6'd2, 1'b0, 1'b0);
        take_out("t1");

        // Empty patch returns the base untouched.
        send_base(32'hFFFF_FFFF);
        send_idx(6'd0);
        check_out("t2", 32'hFFFF_FFFF, 6'd0, 1'b0, 1'b0);
        take_out("t2");

        // Repeated index toggles back; counts twice; non-ascending.
        send_base(32'h0000_00F0);
        send_idx(6'd5);
        send_idx(6'd5);
        send_idx(6'd0);
        check_out("t3", 32'h0000_00F0, 6'd2, 1'b0, ORD);
        take_out("t3");

        // Out-of-range indices: consumed, no toggle, sticky bad_idx.
        send_base(32'h1234_5678);
        send_idx(6'd33);
        send_idx(6'd63);
        send_idx(6'd0);
        check_out("t4", 32'h1234_5678, 6'd0, 1'b1, 1'b0);
        take_out("t4");

        // Output stall: DONE holds while other inputs are waved at it.
        send_base(32'h0000_0001);
        chk("t5_bad_cleared_on_base", {31'd0, bus.bad_idx}, 32'd0);
        send_idx(6'd1);
        send_idx(6'd0);
        bus.idx_valid  = 1'b1;
        bus.idx_in     = 6'd3;
        bus.base_valid = 1'b1;
        bus.base_in    = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_stall_out_valid",  {31'd0, bus.out_valid},  32'd1);
            chk("t5_stall_out_data",   bus.out_data,            32'd0);
            chk("t5_stall_out_count",  {26'd0, bus.out_count},  32'd1);
            chk("t5_stall_idx_ready",  {31'd0, bus.idx_ready},  32'd0);
            chk("t5_stall_base_ready", {31'd0, bus.base_ready}, 32'd0);
        end
        bus.idx_valid  = 1'b0;
        bus.base_valid = 1'b0;
        take_out("t5");

        // Reset in the middle of a patch discards it.
        send_base(32'hFFFF_0000);
        send_idx(6'd1);
        send_idx(6'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_out_valid",  {31'd0, bus.out_valid},  32'd0);
        chk("t6_rst_base_ready", {31'd0, bus.base_ready}, 32'd1);
        chk("t6_rst_idx_ready",  {31'd0, bus.idx_ready},  32'd0);
        chk("t6_rst_out_count",  {26'd0, bus.out_count},  32'd0);
        send_base(32'h0000_000A);
        send_idx(6'd2);
        send_idx(6'd0);
        check_out("t6", 32'h0000_0008, 6'd1, 1'b0, 1'b0);
        take_out("t6");

        // Count saturates at 63; even number of toggles leaves data at base.
        send_base(32'h0000_0000);
        for (int i = 0; i < 64; i++) send_idx(6'd1);
        send_idx(6'd0);
        check_out("t7", 32'h0000_0000, 6'd63, 1'b0, ORD);
        take_out("t7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
